// File: rtl/ip_ram_arbiter.sv
// ip_ram_arbiter: shares one external RAM port between two clients (A, B) with round-robin grant.
// Define ARB_FIXED_PRIORITY_EN to make port A win every tie instead of alternating.
module ip_ram_arbiter #(
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_rd,
    input  logic              a_wr,
    output logic              a_busy,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [7:0]        a_wdata,
    output logic [7:0]        a_rdata,
    output logic              a_rdata_en,
    input  logic              b_rd,
    input  logic              b_wr,
    output logic              b_busy,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [7:0]        b_wdata,
    output logic [7:0]        b_rdata,
    output logic              b_rdata_en,
    output logic              rd,
    output logic              wr,
    input  logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        wdata,
    input  logic [7:0]        rdata,
    input  logic              rdata_en
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GAP       = 2'd1,
        WAIT_READ = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        req_rd, req_wr, port_busy;
    logic [ADDR_W-1:0] req_addr [2];
    logic [7:0]        req_wdata [2];

    logic [1:0]        slot_valid_q, slot_valid_d;
    logic [1:0]        slot_read_q, slot_read_d;
    logic [ADDR_W-1:0] slot_addr_q [2];
    logic [ADDR_W-1:0] slot_addr_d [2];
    logic [7:0]        slot_wdata_q [2];
    logic [7:0]        slot_wdata_d [2];

    logic              owner_q, owner_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        cl_rdata_q [2];
    logic [7:0]        cl_rdata_d [2];
    logic [1:0]        cl_rdata_en_q, cl_rdata_en_d;

    logic              grant_port;
    logic              issue;

    assign req_rd       = {b_rd, a_rd};
    assign req_wr       = {b_wr, a_wr};
    assign req_addr[0]  = a_address;
    assign req_addr[1]  = b_address;
    assign req_wdata[0] = a_wdata;
    assign req_wdata[1] = b_wdata;

    // A port stays busy while its slot is full or while it owns the outstanding read.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port_busy
            assign port_busy[gi] = slot_valid_q[gi] |
                                   ((state_q == WAIT_READ) && (owner_q == 1'(gi)));
        end
    endgenerate

    assign issue = (state_q == IDLE) && !busy && (|slot_valid_q);

`ifdef ARB_FIXED_PRIORITY_EN
    assign grant_port = ~slot_valid_q[0];
`else
    logic last_grant_q, last_grant_d;

    // B wins only when A is empty or A was the previous grantee.
    assign grant_port = slot_valid_q[1] & (~slot_valid_q[0] | ~last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (issue) begin
            last_grant_d = grant_port;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        slot_valid_d  = slot_valid_q;
        slot_read_d   = slot_read_q;
        slot_addr_d   = slot_addr_q;
        slot_wdata_d  = slot_wdata_q;
        owner_d       = owner_q;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        address_d     = address_q;
        wdata_d       = wdata_q;
        cl_rdata_d    = cl_rdata_q;
        cl_rdata_en_d = 2'b00;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    address_d                = slot_addr_q[grant_port];
                    wdata_d                  = slot_wdata_q[grant_port];
                    slot_valid_d[grant_port] = 1'b0;
                    if (slot_read_q[grant_port]) begin
                        rd_d    = 1'b1;
                        owner_d = grant_port;
                        state_d = WAIT_READ;
                    end else begin
                        wr_d    = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            WAIT_READ: begin
                if (rdata_en) begin
                    cl_rdata_d[owner_q]    = rdata;
                    cl_rdata_en_d[owner_q] = 1'b1;
                    state_d                = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A slot that is loadable is never the one being granted this cycle.
        for (int i = 0; i < 2; i++) begin
            if ((req_rd[i] | req_wr[i]) && !port_busy[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_read_d[i]  = req_rd[i];
                slot_addr_d[i]  = req_addr[i];
                slot_wdata_d[i] = req_wdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_valid_q  <= 2'b00;
            slot_read_q   <= 2'b00;
            slot_addr_q   <= '{default: '0};
            slot_wdata_q  <= '{default: '0};
            owner_q       <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            address_q     <= '0;
            wdata_q       <= '0;
            cl_rdata_q    <= '{default: '0};
            cl_rdata_en_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            slot_valid_q  <= slot_valid_d;
            slot_read_q   <= slot_read_d;
            slot_addr_q   <= slot_addr_d;
            slot_wdata_q  <= slot_wdata_d;
            owner_q       <= owner_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            address_q     <= address_d;
            wdata_q       <= wdata_d;
            cl_rdata_q    <= cl_rdata_d;
            cl_rdata_en_q <= cl_rdata_en_d;
        end
    end

    assign a_busy     = port_busy[0];
    assign b_busy     = port_busy[1];
    assign a_rdata    = cl_rdata_q[0];
    assign b_rdata    = cl_rdata_q[1];
    assign a_rdata_en = cl_rdata_en_q[0];
    assign b_rdata_en = cl_rdata_en_q[1];
    assign rd         = rd_q;
    assign wr         = wr_q;
    assign address    = address_q;
    assign wdata      = wdata_q;

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// Scoreboard bench for ip_ram_arbiter: expected downstream accesses and client strobes are
// queued when requests are driven and compared against what the monitor observes.
module tb_ip_ram_arbiter;
    localparam int ADDR_W = 22;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [ADDR_W-1:0] a_address = '0, b_address = '0;
    logic [7:0]        a_wdata = '0, b_wdata = '0;
    logic              a_busy, b_busy, a_rdata_en, b_rdata_en;
    logic [7:0]        a_rdata, b_rdata;
    logic              rd, wr;
    logic              busy = 1'b0;
    logic [ADDR_W-1:0] address;
    logic [7:0]        wdata;
    logic [7:0]        rdata = 8'h00;
    logic              rdata_en = 1'b0;

    ip_ram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .a_rd(a_rd), .a_wr(a_wr), .a_busy(a_busy), .a_address(a_address),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rdata_en(a_rdata_en),
        .b_rd(b_rd), .b_wr(b_wr), .b_busy(b_busy), .b_address(b_address),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_rdata_en(b_rdata_en),
        .rd(rd), .wr(wr), .busy(busy), .address(address), .wdata(wdata),
        .rdata(rdata), .rdata_en(rdata_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_rd;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wd;
        logic              a_bsy;
        logic              b_bsy;
        int                cyc;
    } ds_t;

    typedef struct {
        logic       port;
        logic [7:0] d;
        int         cyc;
    } cli_t;

    ds_t  exp_ds[$], obs_ds[$];
    cli_t exp_cli[$], obs_cli[$];
    ds_t  e, o, mon_ds;
    cli_t ec, oc, mon_cli;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   inject_count = 0, inject_done = 0;
    int   k;
    logic [7:0] resp_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one record per cycle that carries a downstream pulse or a client strobe.
    always @(negedge clk) begin
        if (rd || wr) begin
            mon_ds.is_rd = rd;
            mon_ds.addr  = address;
            mon_ds.wd    = wdata;
            mon_ds.a_bsy = a_busy;
            mon_ds.b_bsy = b_busy;
            mon_ds.cyc   = cyc;
            obs_ds.push_back(mon_ds);
        end
        if (a_rdata_en) begin
            mon_cli.port = 1'b0; mon_cli.d = a_rdata; mon_cli.cyc = cyc;
            obs_cli.push_back(mon_cli);
        end
        if (b_rdata_en) begin
            mon_cli.port = 1'b1; mon_cli.d = b_rdata; mon_cli.cyc = cyc;
            obs_cli.push_back(mon_cli);
        end
    end

    // RAM model: answers each rd 3 cycles later with addr[7:0]^0xA5; also injects stray strobes.
    always begin
        @(negedge clk);
        if (rd) begin
            resp_data = address[7:0] ^ 8'hA5;
            repeat (3) @(posedge clk);
            #1; rdata = resp_data; rdata_en = 1'b1;
            @(posedge clk); #1; rdata_en = 1'b0;
        end else if (inject_count != inject_done) begin
            @(posedge clk); #1; rdata = 8'hC3; rdata_en = 1'b1;
            @(posedge clk); #1; rdata_en = 1'b0;
            inject_done++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
    endtask

    task automatic push_ds(input logic is_rd, input logic [ADDR_W-1:0] ad, input logic [7:0] wd, input int c);
        ds_t t;
        t.is_rd = is_rd; t.addr = ad; t.wd = wd; t.a_bsy = 1'b0; t.b_bsy = 1'b0; t.cyc = c;
        exp_ds.push_back(t);
    endtask

    task automatic push_cli(input logic port, input logic [7:0] d, input int c);
        cli_t t;
        t.port = port; t.d = d; t.cyc = c;
        exp_cli.push_back(t);
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({rd, wr, a_busy, b_busy, a_rdata_en, b_rdata_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rd/wr/abusy/bbusy/aen/ben=%b, want 000000",
                     {rd, wr, a_busy, b_busy, a_rdata_en, b_rdata_en});
        end
        checks++;
        if (address !== '0 || wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got address=%h wdata=%h, want 0/0", address, wdata);
        end
        checks++;
        if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got a=%h b=%h, want 00/00", a_rdata, b_rdata);
        end
        reset = 1'b0;
        tick(2);
        checks++;
        if (obs_ds.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d downstream pulses, want 0", obs_ds.size());
        end
        obs_ds.delete();
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        k = cyc;
        a_wr = 1'b1; a_address = 22'h048234; a_wdata = 8'hAB;
        push_ds(1'b0, 22'h048234, 8'hAB, k + 2);
        tick(1);
        clear_reqs();
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy_hi: got a_busy=%b, want 1", a_busy);
        end
        tick(5);
        while (exp_ds.size() > 0) begin
            e = exp_ds.pop_front();
            checks++;
            if (obs_ds.size() == 0) begin
                errors++;
                $display("FAIL write_issue: got no access, want wr addr=%h", e.addr);
            end else begin
                o = obs_ds.pop_front();
                if (o.is_rd !== e.is_rd || o.addr !== e.addr || o.wd !== e.wd || o.cyc != e.cyc || o.a_bsy !== 1'b0) begin
                    errors++;
                    $display("FAIL write_issue: got rd=%b addr=%h wd=%h cyc=%0d abusy=%b, want rd=0 addr=%h wd=%h cyc=%0d abusy=0",
                             o.is_rd, o.addr, o.wd, o.cyc, o.a_bsy, e.addr, e.wd, e.cyc);
                end
            end
        end
        checks++;
        if (obs_ds.size() != 0) begin
            errors++;
            $display("FAIL write_width: got %0d extra pulse cycles, want 0", obs_ds.size());
        end
        obs_ds.delete();
        $display("test_single_write done");
    endtask

    task automatic test_single_read();
        k = cyc;
        b_rd = 1'b1; b_address = 22'h003FFF; b_wdata = 8'h00;
        push_ds(1'b1, 22'h003FFF, 8'h00, k + 2);
        push_cli(1'b1, 8'h5A, k + 6);
        tick(1);
        clear_reqs();
        tick(10);
        e = exp_ds.pop_front();
        checks++;
        if (obs_ds.size() == 0) begin
            errors++;
            $display("FAIL read_issue: got no access, want rd addr=%h", e.addr);
        end else begin
            o = obs_ds.pop_front();
            if (o.is_rd !== 1'b1 || o.addr !== e.addr || o.cyc != e.cyc || o.b_bsy !== 1'b1) begin
                errors++;
                $display("FAIL read_issue: got rd=%b addr=%h cyc=%0d bbusy=%b, want rd=1 addr=%h cyc=%0d bbusy=1",
                         o.is_rd, o.addr, o.cyc, o.b_bsy, e.addr, e.cyc);
            end
        end
        ec = exp_cli.pop_front();
        checks++;
        if (obs_cli.size() == 0) begin
            errors++;
            $display("FAIL read_data: got no strobe, want port=%b data=%h", ec.port, ec.d);
        end else begin
            oc = obs_cli.pop_front();
            if (oc.port !== ec.port || oc.d !== ec.d || oc.cyc != ec.cyc) begin
                errors++;
                $display("FAIL read_data: got port=%b data=%h cyc=%0d, want port=%b data=%h cyc=%0d",
                         oc.port, oc.d, oc.cyc, ec.port, ec.d, ec.cyc);
            end
        end
        checks++;
        if (obs_cli.size() != 0 || obs_ds.size() != 0 || b_rdata !== 8'h5A || a_rdata !== 8'h00 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL read_after: got extra_strobes=%0d extra_acc=%0d b_rdata=%h a_rdata=%h bbusy=%b, want 0 0 5a 00 0",
                     obs_cli.size(), obs_ds.size(), b_rdata, a_rdata, b_busy);
        end
        obs_cli.delete(); obs_ds.delete();
        $display("test_single_read done");
    endtask

    task automatic test_round_robin();
        // Tie with last grant on B: A first, B once A's data has returned.
        k = cyc;
        a_rd = 1'b1; a_address = 22'h000111;
        b_rd = 1'b1; b_address = 22'h000222;
        push_ds(1'b1, 22'h000111, 8'h00, k + 2);
        push_ds(1'b1, 22'h000222, 8'h00, k + 7);
        push_cli(1'b0, 8'hB4, k + 6);
        push_cli(1'b1, 8'h87, k + 11);
        tick(1);
        clear_reqs();
        tick(16);
        // A lone A write leaves the last grant on A before the second tie.
        k = cyc;
        a_wr = 1'b1; a_address = 22'h000333; a_wdata = 8'h33;
        push_ds(1'b0, 22'h000333, 8'h33, k + 2);
        tick(1);
        clear_reqs();
        tick(5);
        k = cyc;
        a_wr = 1'b1; a_address = 22'h000444; a_wdata = 8'h44;
        b_wr = 1'b1; b_address = 22'h000555; b_wdata = 8'h55;
`ifdef ARB_FIXED_PRIORITY_EN
        push_ds(1'b0, 22'h000444, 8'h44, k + 2);
        push_ds(1'b0, 22'h000555, 8'h55, k + 4);
`else
        push_ds(1'b0, 22'h000555, 8'h55, k + 2);
        push_ds(1'b0, 22'h000444, 8'h44, k + 4);
`endif
        tick(1);
        clear_reqs();
        tick(8);
        while (exp_ds.size() > 0) begin
            e = exp_ds.pop_front();
            checks++;
            if (obs_ds.size() == 0) begin
                errors++;
                $display("FAIL tie_order: got no access, want rd=%b addr=%h", e.is_rd, e.addr);
            end else begin
                o = obs_ds.pop_front();
                if (o.is_rd !== e.is_rd || o.addr !== e.addr || o.cyc != e.cyc || (!e.is_rd && o.wd !== e.wd)) begin
                    errors++;
                    $display("FAIL tie_order: got rd=%b addr=%h wd=%h cyc=%0d, want rd=%b addr=%h wd=%h cyc=%0d",
                             o.is_rd, o.addr, o.wd, o.cyc, e.is_rd, e.addr, e.wd, e.cyc);
                end
            end
        end
        while (exp_cli.size() > 0) begin
            ec = exp_cli.pop_front();
            checks++;
            if (obs_cli.size() == 0) begin
                errors++;
                $display("FAIL tie_data: got no strobe, want port=%b data=%h", ec.port, ec.d);
            end else begin
                oc = obs_cli.pop_front();
                if (oc.port !== ec.port || oc.d !== ec.d || oc.cyc != ec.cyc) begin
                    errors++;
                    $display("FAIL tie_data: got port=%b data=%h cyc=%0d, want port=%b data=%h cyc=%0d",
                             oc.port, oc.d, oc.cyc, ec.port, ec.d, ec.cyc);
                end
            end
        end
        checks++;
        if (obs_ds.size() != 0 || obs_cli.size() != 0) begin
            errors++;
            $display("FAIL tie_extra: got %0d accesses %0d strobes left, want 0 0", obs_ds.size(), obs_cli.size());
        end
        obs_ds.delete(); obs_cli.delete();
        $display("test_round_robin done");
    endtask

    task automatic test_stall();
        busy = 1'b1;
        a_rd = 1'b1; a_address = 22'h001234;
        tick(1);
        clear_reqs();
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (a_busy !== 1'b1 || rd !== 1'b0 || wr !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got a_busy=%b rd=%b wr=%b, want 1 0 0", i, a_busy, rd, wr);
            end
        end
        k = cyc;
        busy = 1'b0;
        push_ds(1'b1, 22'h001234, 8'h00, k + 1);
        push_cli(1'b0, 8'h91, k + 5);
        tick(10);
        e = exp_ds.pop_front();
        checks++;
        if (obs_ds.size() != 1) begin
            errors++;
            $display("FAIL stall_issue: got %0d accesses, want 1 rd addr=%h", obs_ds.size(), e.addr);
        end else begin
            o = obs_ds.pop_front();
            if (o.is_rd !== 1'b1 || o.addr !== e.addr || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL stall_issue: got rd=%b addr=%h cyc=%0d, want rd=1 addr=%h cyc=%0d",
                         o.is_rd, o.addr, o.cyc, e.addr, e.cyc);
            end
        end
        ec = exp_cli.pop_front();
        checks++;
        if (obs_cli.size() != 1) begin
            errors++;
            $display("FAIL stall_data: got %0d strobes, want 1 with data=%h", obs_cli.size(), ec.d);
        end else begin
            oc = obs_cli.pop_front();
            if (oc.port !== ec.port || oc.d !== ec.d || oc.cyc != ec.cyc) begin
                errors++;
                $display("FAIL stall_data: got port=%b data=%h cyc=%0d, want port=%b data=%h cyc=%0d",
                         oc.port, oc.d, oc.cyc, ec.port, ec.d, ec.cyc);
            end
        end
        obs_ds.delete(); obs_cli.delete();
        $display("test_stall done");
    endtask

    task automatic test_protocol_guard();
        k = cyc;
        a_wr = 1'b1; a_address = 22'h000AAA; a_wdata = 8'h11;
        push_ds(1'b0, 22'h000AAA, 8'h11, k + 2);
        tick(1);
        a_address = 22'h000BBB; a_wdata = 8'h22;
        tick(1);
        clear_reqs();
        tick(6);
        e = exp_ds.pop_front();
        checks++;
        if (obs_ds.size() != 1) begin
            errors++;
            $display("FAIL guard_drop: got %0d writes, want 1 to addr=%h", obs_ds.size(), e.addr);
        end else begin
            o = obs_ds.pop_front();
            if (o.is_rd !== 1'b0 || o.addr !== e.addr || o.wd !== e.wd || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL guard_drop: got rd=%b addr=%h wd=%h cyc=%0d, want rd=0 addr=%h wd=%h cyc=%0d",
                         o.is_rd, o.addr, o.wd, o.cyc, e.addr, e.wd, e.cyc);
            end
        end
        checks++;
        if (address !== 22'h000AAA || wdata !== 8'h11) begin
            errors++;
            $display("FAIL guard_hold: got address=%h wdata=%h, want 000aaa/11", address, wdata);
        end
        inject_count++;
        tick(5);
        checks++;
        if (obs_cli.size() != 0 || a_rdata !== 8'h91 || b_rdata !== 8'h87) begin
            errors++;
            $display("FAIL guard_stray: got strobes=%0d a_rdata=%h b_rdata=%h, want 0 91 87",
                     obs_cli.size(), a_rdata, b_rdata);
        end
        obs_ds.delete(); obs_cli.delete();
        $display("test_protocol_guard done");
    endtask

    task automatic test_reset_mid_read();
        k = cyc;
        a_rd = 1'b1; a_address = 22'h000777;
        push_ds(1'b1, 22'h000777, 8'h00, k + 2);
        tick(1);
        clear_reqs();
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(6);
        e = exp_ds.pop_front();
        checks++;
        if (obs_ds.size() != 1) begin
            errors++;
            $display("FAIL rst_read_issue: got %0d accesses, want 1 rd addr=%h", obs_ds.size(), e.addr);
        end else begin
            o = obs_ds.pop_front();
            if (o.is_rd !== 1'b1 || o.addr !== e.addr || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL rst_read_issue: got rd=%b addr=%h cyc=%0d, want rd=1 addr=%h cyc=%0d",
                         o.is_rd, o.addr, o.cyc, e.addr, e.cyc);
            end
        end
        checks++;
        if (obs_cli.size() != 0) begin
            errors++;
            $display("FAIL rst_late_data: got %0d client strobes, want 0", obs_cli.size());
        end
        checks++;
        if ({rd, wr, a_busy, b_busy} !== 4'b0 || address !== '0 || wdata !== 8'h00 ||
            a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_outputs: got rd/wr/abusy/bbusy=%b address=%h wdata=%h a=%h b=%h, want 0000 0 0 0 0",
                     {rd, wr, a_busy, b_busy}, address, wdata, a_rdata, b_rdata);
        end
        obs_ds.delete(); obs_cli.delete();
        $display("test_reset_mid_read done");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_stall();
        test_protocol_guard();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
